// File: rtl/decode_scoreboard_pkg.sv
// Shared widths, the derived output-count helper and the default one-hot vector type
// for the decode scoreboard.
package decode_sb_pkg;

  localparam int DEFAULT_ADDR_W = 5;

  function automatic int num_out(input int addr_w);
    return 2 ** addr_w;
  endfunction

  typedef logic [num_out(DEFAULT_ADDR_W)-1:0] onehot_t;

endpackage

// File: rtl/decode_scoreboard_if.sv
// Issue/commit request bundle and decoded/scoreboard outputs. The master drives requests,
// and the slave (the scoreboard) answers with stall, enables and pending state.
interface decode_scoreboard_if
  import decode_sb_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) ();

  localparam int NUM_OUT = num_out(ADDR_W);

  logic               iss_en;
  logic [ADDR_W-1:0]  iss_addr;
  logic               clr_en;
  logic [ADDR_W-1:0]  clr_addr;
  logic               stall;
  logic               out_valid;
  logic [NUM_OUT-1:0] out_onehot;
  logic [NUM_OUT-1:0] busy;
  logic               err;

  modport master (
    output iss_en, iss_addr, clr_en, clr_addr,
    input  stall, out_valid, out_onehot, busy, err
  );

  modport slave (
    input  iss_en, iss_addr, clr_en, clr_addr,
    output stall, out_valid, out_onehot, busy, err
  );

endinterface

// File: rtl/decode_scoreboard_onehot_dec.sv
// Combinational index to one-hot decoder with enable; all zeros when disabled.
// Zero latency, no flow control.
module onehot_dec
  import decode_sb_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic                       en,
  input  logic [ADDR_W-1:0]          idx,
  output logic [num_out(ADDR_W)-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/decode_scoreboard.sv
// Registered one-hot write-enable decoder with a pending-write scoreboard: 1-cycle latency,
// and a combinational stall on an issue to a busy index. The sticky err flag exists only when DECODE_SB_ERR_EN is defined.
module decode_scoreboard
  import decode_sb_pkg::*;
#(
  parameter int ADDR_W       = DEFAULT_ADDR_W,
  parameter int ZERO_PROTECT = 1
) (
  input  logic               clock,
  input  logic               reset,
  decode_scoreboard_if.slave bus
);

  localparam int NUM_OUT = num_out(ADDR_W);

  logic               iss_zero;
  logic               clr_zero;
  logic               same_idx;
  logic               stall;
  logic               acc;
  logic               iss_dec_en;
  logic               clr_dec_en;
  logic [NUM_OUT-1:0] iss_oh;
  logic [NUM_OUT-1:0] clr_oh;

  logic               out_valid_d, out_valid_q;
  logic [NUM_OUT-1:0] out_onehot_d, out_onehot_q;
  logic [NUM_OUT-1:0] busy_d, busy_q;

  // Index 0 under protection never decodes; busy[0] then stays 0, so it can never stall.
  always_comb begin
    iss_zero   = (ZERO_PROTECT != 0) && (bus.iss_addr == '0);
    clr_zero   = (ZERO_PROTECT != 0) && (bus.clr_addr == '0);
    same_idx   = bus.clr_en && (bus.clr_addr == bus.iss_addr);
    stall      = !reset && bus.iss_en && busy_q[bus.iss_addr] && !same_idx;
    acc        = bus.iss_en && !stall;
    iss_dec_en = acc && !iss_zero;
    clr_dec_en = bus.clr_en && !clr_zero;
  end

  onehot_dec #(.ADDR_W(ADDR_W)) u_iss_dec (
    .en     (iss_dec_en),
    .idx    (bus.iss_addr),
    .onehot (iss_oh)
  );

  onehot_dec #(.ADDR_W(ADDR_W)) u_clr_dec (
    .en     (clr_dec_en),
    .idx    (bus.clr_addr),
    .onehot (clr_oh)
  );

  // Set after clear, so a same-index clear+issue leaves the bit pending.
  always_comb begin
    out_valid_d  = acc;
    out_onehot_d = iss_oh;
    busy_d       = (busy_q & ~clr_oh) | iss_oh;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_onehot_q <= '0;
      busy_q       <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_onehot_q <= out_onehot_d;
      busy_q       <= busy_d;
    end
  end

`ifdef DECODE_SB_ERR_EN
  logic err_d, err_q;

  always_comb begin
    err_d = err_q;
    if (clr_dec_en && !busy_q[bus.clr_addr] && !(acc && (bus.iss_addr == bus.clr_addr))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.stall      = stall;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_onehot = out_onehot_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_decode_scoreboard.sv
// Directed-vector bench for decode_scoreboard: main table on the default build plus
// hand sequences for zero-protect off, mid-operation reset and width sweeps.
module tb_decode_scoreboard;
  import decode_sb_pkg::*;

`ifdef DECODE_SB_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  decode_scoreboard_if #(.ADDR_W(5)) if5 ();
  decode_scoreboard_if #(.ADDR_W(5)) ifz ();
  decode_scoreboard_if #(.ADDR_W(3)) if3 ();
  decode_scoreboard_if #(.ADDR_W(6)) if6 ();

  decode_scoreboard #(.ADDR_W(5), .ZERO_PROTECT(1)) dut5 (.clock(clock), .reset(reset), .bus(if5.slave));
  decode_scoreboard #(.ADDR_W(5), .ZERO_PROTECT(0)) dutz (.clock(clock), .reset(reset), .bus(ifz.slave));
  decode_scoreboard #(.ADDR_W(3), .ZERO_PROTECT(0)) dut3 (.clock(clock), .reset(reset), .bus(if3.slave));
  decode_scoreboard #(.ADDR_W(6), .ZERO_PROTECT(0)) dut6 (.clock(clock), .reset(reset), .bus(if6.slave));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        clr_en;
    logic [4:0]  clr_addr;
    logic        stall;
    logic        vld;
    logic [31:0] oh;
    logic [31:0] busy;
    logic        err_en;
  } vec_t;

  vec_t vecs[15];
  onehot_t exp_busy;

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    if5.iss_en = 1'b0; if5.iss_addr = '0; if5.clr_en = 1'b0; if5.clr_addr = '0;
    ifz.iss_en = 1'b0; ifz.iss_addr = '0; ifz.clr_en = 1'b0; ifz.clr_addr = '0;
    if3.iss_en = 1'b0; if3.iss_addr = '0; if3.clr_en = 1'b0; if3.clr_addr = '0;
    if6.iss_en = 1'b0; if6.iss_addr = '0; if6.clr_en = 1'b0; if6.clr_addr = '0;

    //            rst   iss   addr   clr   addr   stall vld  onehot         busy           err(enabled)
    vecs[0]  = '{1'b1, 1'b1, 5'd5,  1'b0, 5'd0,  1'b0, 1'b0, 32'h0,         32'h0,         1'b0};
    vecs[1]  = '{1'b0, 1'b1, 5'd5,  1'b0, 5'd0,  1'b0, 1'b1, 32'h0000_0020, 32'h0000_0020, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 5'd5,  1'b0, 5'd0,  1'b1, 1'b0, 32'h0,         32'h0000_0020, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 5'd5,  1'b1, 5'd5,  1'b0, 1'b1, 32'h0000_0020, 32'h0000_0020, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 32'h0,         32'h0000_0020, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 5'd0,  1'b1, 5'd0,  1'b0, 1'b0, 32'h0,         32'h0000_0020, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 5'd2,  1'b1, 5'd5,  1'b0, 1'b1, 32'h0000_0004, 32'h0000_0004, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 5'd1,  1'b0, 5'd0,  1'b0, 1'b1, 32'h0000_0002, 32'h0000_0006, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 5'd31, 1'b1, 5'd1,  1'b0, 1'b1, 32'h8000_0000, 32'h8000_0004, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 5'd3,  1'b1, 5'd3,  1'b0, 1'b1, 32'h0000_0008, 32'h8000_000C, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 5'd0,  1'b1, 5'd9,  1'b0, 1'b0, 32'h0,         32'h8000_000C, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 32'h0,         32'h8000_000C, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 5'd2,  1'b1, 5'd2,  1'b0, 1'b1, 32'h0000_0004, 32'h8000_000C, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 5'd31, 1'b1, 5'd3,  1'b1, 1'b0, 32'h0,         32'h8000_0004, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 5'd31, 1'b0, 5'd0,  1'b1, 1'b0, 32'h0,         32'h8000_0004, 1'b1};

    @(negedge clock);
    for (int v = 0; v < 15; v++) begin
      reset        = vecs[v].rst;
      if5.iss_en   = vecs[v].iss_en;
      if5.iss_addr = vecs[v].iss_addr;
      if5.clr_en   = vecs[v].clr_en;
      if5.clr_addr = vecs[v].clr_addr;
      #1;
      chk($sformatf("v%0d stall", v), 64'(if5.stall), 64'(vecs[v].stall));
      @(posedge clock);
      #1;
      chk($sformatf("v%0d out_valid", v), 64'(if5.out_valid), 64'(vecs[v].vld));
      chk($sformatf("v%0d out_onehot", v), 64'(if5.out_onehot), 64'(vecs[v].oh));
      chk($sformatf("v%0d busy", v), 64'(if5.busy), 64'(vecs[v].busy));
      chk($sformatf("v%0d err", v), 64'(if5.err), 64'(vecs[v].err_en & ERR_EN));
      @(negedge clock);
    end

    // Fill 1..31 using same-index clear bypass, then reset mid-operation.
    if5.clr_en = 1'b1;
    for (int i = 1; i < 32; i++) begin
      if5.iss_en   = 1'b1;
      if5.iss_addr = 5'(i);
      if5.clr_addr = 5'(i);
      @(negedge clock);
    end
    if5.clr_en = 1'b0;
    exp_busy = 32'hFFFF_FFFE;
    chk("fill busy", 64'(if5.busy), 64'(exp_busy));
    chk("fill err held", 64'(if5.err), 64'(ERR_EN));
    reset        = 1'b1;
    if5.iss_en   = 1'b1;
    if5.iss_addr = 5'd7;
    #1;
    chk("reset stall", 64'(if5.stall), 64'd0);
    @(posedge clock);
    #1;
    chk("reset busy", 64'(if5.busy), 64'd0);
    chk("reset out_valid", 64'(if5.out_valid), 64'd0);
    chk("reset out_onehot", 64'(if5.out_onehot), 64'd0);
    chk("reset err", 64'(if5.err), 64'd0);
    @(negedge clock);
    reset      = 1'b0;
    if5.iss_en = 1'b0;

    // Zero protection off: index 0 behaves like any other.
    ifz.iss_en = 1'b1; ifz.iss_addr = 5'd0;
    #1;
    chk("zp0 stall first", 64'(ifz.stall), 64'd0);
    @(posedge clock); #1;
    chk("zp0 out_valid", 64'(ifz.out_valid), 64'd1);
    chk("zp0 out_onehot", 64'(ifz.out_onehot), 64'h1);
    chk("zp0 busy", 64'(ifz.busy), 64'h1);
    @(negedge clock); #1;
    chk("zp0 stall busy", 64'(ifz.stall), 64'd1);
    @(negedge clock);
    ifz.iss_en = 1'b0; ifz.clr_en = 1'b1; ifz.clr_addr = 5'd0;
    @(posedge clock); #1;
    chk("zp0 clear busy", 64'(ifz.busy), 64'h0);
    chk("zp0 clear err", 64'(ifz.err), 64'd0);
    @(negedge clock);
    ifz.clr_en = 1'b0;

    // Width sweeps: every index decodes to a single bit at its own position.
    for (int i = 0; i < 64; i++) begin
      if6.iss_en = 1'b1; if6.iss_addr = 6'(i); if6.clr_en = 1'b1; if6.clr_addr = 6'(i);
      if3.iss_en = (i < 8); if3.iss_addr = 3'(i); if3.clr_en = (i < 8); if3.clr_addr = 3'(i);
      @(posedge clock); #1;
      chk($sformatf("w6 idx%0d onehot", i), 64'(if6.out_onehot), 64'd1 << i);
      chk($sformatf("w6 idx%0d busy bit", i), 64'(if6.busy[i]), 64'd1);
      if (i < 8) begin
        chk($sformatf("w3 idx%0d onehot", i), 64'(if3.out_onehot), 64'd1 << i);
        chk($sformatf("w3 idx%0d valid", i), 64'(if3.out_valid), 64'd1);
      end
      @(negedge clock);
    end
    chk("w6 busy all", 64'(if6.busy), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("w3 busy all", 64'(if3.busy), 64'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
